// File: rtl/wb_merge_if.sv
// wb_merge_if: writeback bundle (alu_*/lsu_* result handshakes, wEN/wAddr/wData RF write, chk_addr/chk_hit hazard query, busy); slave = merger, master = driver
interface wb_merge_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [RF_ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     lsu_valid;
  logic                     lsu_ready;
  logic [RF_ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0]    lsu_data;
  logic                     wEN;
  logic [RF_ADDR_WIDTH-1:0] wAddr;
  logic [DATA_WIDTH-1:0]    wData;
  logic [RF_ADDR_WIDTH-1:0] chk_addr;
  logic                     chk_hit;
  logic                     busy;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, chk_addr,
    input  alu_ready, lsu_ready, wEN, wAddr, wData, chk_hit, busy
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, chk_addr,
    output alu_ready, lsu_ready, wEN, wAddr, wData, chk_hit, busy
  );
endinterface

// File: rtl/wb_merge.sv
// wb_merge: merges ALU results and a 2-deep in-order LSU queue into one registered RF write port with anti-starvation; ports clk, rst, bus (wb_merge_if.slave)
module wb_merge #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int STARVE_MAX    = 3
) (
  input logic       clk,
  input logic       rst,
  wb_merge_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 2);
  logic [RF_ADDR_WIDTH-1:0] rd_q [2];
  logic [DATA_WIDTH-1:0]    data_q [2];
  logic                     head_q, tail_q;
  logic [1:0]               count_q, count_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     wen_q, wen_d;
  logic [RF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     has_q, head_win, lsu_take, alu_win, alu_wr, pop, bypass, push;
  always_comb begin
    has_q    = count_q != 2'd0;
    head_win = has_q && starve_q == SW'(STARVE_MAX);
    lsu_take = bus.lsu_valid && count_q != 2'd2 && bus.lsu_rd != '0;
    alu_win  = !head_win && bus.alu_valid;
    alu_wr   = alu_win && bus.alu_rd != '0;
    pop      = head_win || (!bus.alu_valid && has_q);
    bypass   = !bus.alu_valid && !has_q && lsu_take;
    push     = lsu_take && !bypass;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    starve_d = (pop || !has_q) ? '0 :
               (alu_win && starve_q != SW'(STARVE_MAX)) ? starve_q + SW'(1) : starve_q;
    wen_d    = pop || alu_wr || bypass;
    waddr_d  = pop ? rd_q[head_q] : alu_wr ? bus.alu_rd : bypass ? bus.lsu_rd : waddr_q;
    wdata_d  = pop ? data_q[head_q] : alu_wr ? bus.alu_data : bypass ? bus.lsu_data : wdata_q;
  end
  assign bus.lsu_ready = count_q != 2'd2;
  assign bus.alu_ready = !head_win;
  assign bus.busy      = has_q;
  assign bus.wEN       = wen_q;
  assign bus.wAddr     = waddr_q;
  assign bus.wData     = wdata_q;
  assign bus.chk_hit   = bus.chk_addr != '0 &&
                         ((has_q && rd_q[head_q] == bus.chk_addr) ||
                          (count_q == 2'd2 && rd_q[~head_q] == bus.chk_addr) ||
                          (wen_q && waddr_q == bus.chk_addr));
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      starve_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      head_q   <= head_q ^ pop;
      tail_q   <= tail_q ^ push;
      count_q  <= count_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      if (push) begin
        rd_q[tail_q]   <= bus.lsu_rd;
        data_q[tail_q] <= bus.lsu_data;
      end
    end
  end
endmodule
